// File: rtl/ysyx_22041461_mem_arbiter.sv
// ysyx_22041461_mem_arbiter
// Shares one memory port between the instruction-fetch (IF) and load/store
// (LS) requesters. One transaction is in flight at a time. Simultaneous
// requests are granted round-robin. The memory port is held until it is
// acknowledged or times out, then a one-cycle response pulse goes to the owner.
module ysyx_22041461_mem_arbiter #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_resp_valid,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_resp_err,
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic                ls_wen,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_wmask,
   output logic                ls_resp_valid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                ls_resp_err,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
   localparam bit TIMEOUT_EN = (MAX_WAIT > 0);
   // The last WAIT cycle before a timeout; unused when the timeout is disabled.
   localparam logic [CNT_W-1:0] CNT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   typedef enum logic {G_IF, G_LS} grant_t;

   state_t            state_q, state_d;
   grant_t            last_grant_q;
   grant_t            owner_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              timeout;

   // State register; an asynchronous reset discards any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state, grant arbitration (ready) and timeout detection.
   always_comb begin
      state_d      = state_q;
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;
      timeout      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if_req_ready = if_req_valid && (!ls_req_valid || last_grant_q == G_LS);
            ls_req_ready = ls_req_valid && (!if_req_valid || last_grant_q == G_IF);
            if (if_req_ready || ls_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            timeout = TIMEOUT_EN && (cnt_q == CNT_LAST) && !mem_ack;
            if (mem_ack || timeout) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request capture on accept, wait counting, and response capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr     <= '0;
         mem_wen      <= 1'b0;
         mem_wdata    <= '0;
         mem_wmask    <= '0;
         last_grant_q <= G_LS;
         owner_q      <= G_IF;
         cnt_q        <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (if_req_ready) begin
                  mem_addr     <= if_addr;
                  mem_wen      <= 1'b0;
                  mem_wdata    <= '0;
                  mem_wmask    <= '0;
                  owner_q      <= G_IF;
                  last_grant_q <= G_IF;
                  cnt_q        <= '0;
               end else if (ls_req_ready) begin
                  mem_addr     <= ls_addr;
                  mem_wen      <= ls_wen;
                  mem_wdata    <= ls_wdata;
                  mem_wmask    <= ls_wen ? ls_wmask : '0;
                  owner_q      <= G_LS;
                  last_grant_q <= G_LS;
                  cnt_q        <= '0;
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  rdata_q <= mem_wen ? '0 : mem_rdata;
                  err_q   <= 1'b0;
               end else if (timeout) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req       = (state_q == S_WAIT);
   assign busy          = (state_q != S_IDLE);
   assign if_resp_valid = (state_q == S_RESP) && (owner_q == G_IF);
   assign ls_resp_valid = (state_q == S_RESP) && (owner_q == G_LS);
   assign if_rdata      = (owner_q == G_IF) ? rdata_q : '0;
   assign ls_rdata      = (owner_q == G_LS) ? rdata_q : '0;
   assign if_resp_err   = if_resp_valid && err_q;
   assign ls_resp_err   = ls_resp_valid && err_q;

endmodule

// File: tb/tb_ysyx_22041461_mem_arbiter.sv
// Bench for ysyx_22041461_mem_arbiter: a table of directed transactions, a
// reset-in-WAIT sequence, and random transactions checked against a
// transaction-level model of grant order, response data and timeout.
module tb_ysyx_22041461_mem_arbiter;

   localparam int MW = 4;

   logic        clk, rst;
   logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
   logic [63:0] if_addr, if_rdata;
   logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
   logic [63:0] ls_addr, ls_wdata, ls_rdata;
   logic [7:0]  ls_wmask, mem_wmask;
   logic        mem_req, mem_wen, mem_ack, busy;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   logic model_last_ls;

   ysyx_22041461_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
      .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
      .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic        lv;
      logic [63:0] ia;
      logic [63:0] la;
      logic        w;
      logic [63:0] wd;
      logic [7:0]  wm;
      int          dly;     // ack delay in WAIT cycles; >= MW means timeout
      logic [63:0] md;
      logic        exp_if;
      logic [63:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full transaction, starting just after a posedge with the DUT idle.
   task automatic run_txn(input logic iv, input logic lv, input logic [63:0] ia,
                          input logic [63:0] la, input logic w, input logic [63:0] wd,
                          input logic [7:0] wm, input int dly, input logic [63:0] md,
                          input logic exp_if, input logic [63:0] exp_rd, input logic exp_err);
      logic [63:0] ea;
      logic        ew;
      logic [7:0]  ewm;
      int          last;
      int          req_cnt;
      int          bad;
      ea  = exp_if ? ia : la;
      ew  = exp_if ? 1'b0 : w;
      ewm = ew ? wm : 8'h00;
      last = (dly < MW) ? dly : MW - 1;
      req_cnt = 0;
      bad = 0;
      if_req_valid = iv; ls_req_valid = lv;
      if_addr = ia; ls_addr = la; ls_wen = w; ls_wdata = wd; ls_wmask = wm;
      mem_ack = 1'b1; mem_rdata = 64'hDEAD;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("if_ready", 64'(if_req_ready), 64'(exp_if));
      chk("ls_ready", 64'(ls_req_ready), 64'(!exp_if));
      @(posedge clk); #1;
      for (int c = 0; c <= last; c++) begin
         if_req_valid = 1'($urandom_range(0, 1));
         ls_req_valid = 1'($urandom_range(0, 1));
         if_addr  = {$urandom, $urandom};
         ls_addr  = {$urandom, $urandom};
         ls_wen   = 1'($urandom_range(0, 1));
         ls_wdata = {$urandom, $urandom};
         ls_wmask = 8'($urandom);
         mem_ack   = (c == dly);
         mem_rdata = (c == dly) ? md : 64'hDEAD_DEAD_DEAD_DEAD;
         @(negedge clk);
         if (mem_req) req_cnt++;
         if (mem_addr !== ea || mem_wen !== ew || mem_wmask !== ewm ||
             (ew && mem_wdata !== wd) || if_req_ready || ls_req_ready) bad++;
         @(posedge clk); #1;
      end
      mem_ack = 1'b1; mem_rdata = 64'hDEAD;
      @(negedge clk);
      chk("req_cycles", 64'(req_cnt), 64'(last + 1));
      chk("mem_hold", 64'(bad), 64'd0);
      chk("if_resp_valid", 64'(if_resp_valid), 64'(exp_if));
      chk("ls_resp_valid", 64'(ls_resp_valid), 64'(!exp_if));
      chk("resp_rdata", exp_if ? if_rdata : ls_rdata, exp_rd);
      chk("resp_err", 64'(exp_if ? if_resp_err : ls_resp_err), 64'(exp_err));
      chk("resp_req_low", 64'(mem_req), 64'd0);
      @(posedge clk); #1;
      mem_ack = 1'b0; if_req_valid = 1'b0; ls_req_valid = 1'b0;
   endtask

   initial begin
      int bad;
      logic iv, lv, w, exp_if, exp_err;
      logic [63:0] md, exp_rd;
      int dly;

      tbl[0] = '{1'b1, 1'b1, 64'h8000_0000, 64'h8000_0200, 1'b1, 64'h55, 8'hFF, 0,
                 64'h0000_0013_0000_0093, 1'b1, 64'h0000_0013_0000_0093, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 64'h8000_0004, 64'h8000_0100, 1'b0, 64'h0, 8'hFF, 1,
                 64'h1111_2222_3333_4444, 1'b0, 64'h1111_2222_3333_4444, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 64'h8000_0008, 64'h8000_0300, 1'b0, 64'h0, 8'h00, 2,
                 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 64'h8000_000C, 64'h8000_0008, 1'b1, 64'h0123_4567_89AB_CDEF,
                 8'hF0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 64'h0, 64'h8000_0400, 1'b0, 64'h0, 8'h00, 99,
                 64'h1234, 1'b0, 64'h0, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 64'h8000_0010, 64'h0, 1'b0, 64'h0, 8'h00, 5,
                 64'h5678, 1'b1, 64'h0, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 64'h0, 64'h8000_0500, 1'b0, 64'h0, 8'h00, 0,
                 64'h9ABC, 1'b0, 64'h9ABC, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 64'h8000_0014, 64'h8000_0600, 1'b0, 64'h0, 8'h00, 1,
                 64'hCAFE, 1'b1, 64'hCAFE, 1'b0};

      rst = 1'b1;
      if_req_valid = 1'b0; ls_req_valid = 1'b0; if_addr = '0; ls_addr = '0;
      ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_resp", 64'({if_resp_valid, ls_resp_valid, if_resp_err, ls_resp_err}), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_last_ls = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i].iv, tbl[i].lv, tbl[i].ia, tbl[i].la, tbl[i].w, tbl[i].wd, tbl[i].wm,
                 tbl[i].dly, tbl[i].md, tbl[i].exp_if, tbl[i].exp_rd, tbl[i].exp_err);
         model_last_ls = !tbl[i].exp_if;
      end

      // Reset while waiting on memory: port and busy drop at once, no response follows.
      if_req_valid = 1'b1; if_addr = 64'h8000_0040; mem_ack = 1'b0;
      @(posedge clk); #1;
      if_req_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_req", 64'(mem_req), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_req", 64'(mem_req), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_resp", 64'({if_resp_valid, ls_resp_valid}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_last_ls = 1'b1;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         mem_ack = 1'b1; mem_rdata = 64'hDEAD;
         @(negedge clk);
         if (if_resp_valid || ls_resp_valid || busy) bad++;
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      chk("post_rst_quiet", 64'(bad), 64'd0);
      run_txn(1'b1, 1'b1, 64'h8000_0080, 64'h8000_0800, 1'b0, 64'h0, 8'h00, 0,
              64'h0BAD_F00D, 1'b1, 64'h0BAD_F00D, 1'b0);
      model_last_ls = 1'b0;

      for (int n = 0; n < 40; n++) begin
         iv = 1'($urandom_range(0, 1));
         lv = 1'($urandom_range(0, 1));
         if (!iv && !lv) iv = 1'b1;
         w   = 1'($urandom_range(0, 1));
         dly = int'($urandom_range(0, 6));
         md  = {$urandom, $urandom};
         exp_if  = iv && (!lv || model_last_ls);
         exp_err = (dly >= MW);
         exp_rd  = (exp_err || (!exp_if && w)) ? 64'h0 : md;
         run_txn(iv, lv, {$urandom, $urandom}, {$urandom, $urandom}, w, {$urandom, $urandom},
                 8'($urandom), dly, md, exp_if, exp_rd, exp_err);
         model_last_ls = !exp_if;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
